// File: rtl/hex_display_scanner.sv
// hex_display_scanner: time-multiplexed scanner for an N-digit common-anode
// 7-segment display. Captures a packed hex value and decimal points, then
// steps through the digit slots. Each slot opens with an all-off blank interval
// to prevent ghosting. Leading zeros can be suppressed. Every output is decoded
// from registered state.
module hex_display_scanner #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_CYC     = 500,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [4*NUM_DIGITS-1:0]       value_in,
    input  logic                          load,
    input  logic                          lz_en,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    output logic [3:0]                    nib_out,
    output logic [NUM_DIGITS-1:0]         an_out,
    output logic                          dp_out,
    output logic                          blank_out,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_tick
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [0:0] PH_BLANK = 1'b0;
    localparam logic [0:0] PH_SHOW  = 1'b1;
    // With no blank interval the slot starts directly in SHOW
    localparam logic [0:0] PH_START = (BLANK_CYC == 0) ? PH_SHOW : PH_BLANK;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] value_reg;
    logic [NUM_DIGITS-1:0]   dp_reg;
    logic                    lz_reg;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [0:0]              phase;

    logic                    slot_end;
    logic [NUM_DIGITS-1:0]   upper_zero;
    logic [NUM_DIGITS-1:0]   suppress;
    logic                    sel_supp;
    logic                    sel_dp;
    logic                    digit_on;
    logic [NUM_DIGITS-1:0]   an_vec;

    assign slot_end = (cnt == CNT_LAST);

    // Capture displayed value and decimal points on the load strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_reg <= '0;
            dp_reg    <= '0;
        end else if (load) begin
            value_reg <= value_in;
            dp_reg    <= dp_in;
        end
    end

    // Register lz_en so suppression has no combinational path from the input
    always_ff @(posedge clk) begin
        if (!rst_n) lz_reg <= 1'b0;
        else        lz_reg <= lz_en;
    end

    // Slot prescaler and digit index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Phase FSM: blank interval at slot start, then show until slot end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase <= PH_START;
        end else if (slot_end) begin
            phase <= PH_START;
        end else if ((BLANK_CYC > 0) && (cnt == BLANK_LAST)) begin
            phase <= PH_SHOW;
        end
    end

    // Leading-zero suppression: digit i blanked when it and all higher nibbles are zero
    always_comb begin
        upper_zero = '0;
        suppress   = '0;
        upper_zero[NUM_DIGITS-1] = (value_reg[4*(NUM_DIGITS-1) +: 4] == 4'h0);
        for (int unsigned i = NUM_DIGITS - 1; i > 0; i--) begin
            upper_zero[i-1] = upper_zero[i] && (value_reg[4*(i-1) +: 4] == 4'h0);
        end
        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
            suppress[i] = lz_reg && upper_zero[i];
        end
    end

    // Select the current slot's nibble, decimal point and suppression flag
    always_comb begin
        nib_out  = '0;
        sel_supp = 1'b0;
        sel_dp   = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib_out  = value_reg[4*i +: 4];
                sel_supp = suppress[i];
                sel_dp   = dp_reg[i];
            end
        end
    end

    // Digit enable decode; at most one digit active, none during blank
    always_comb begin
        digit_on = (phase == PH_SHOW) && !sel_supp;
        an_vec   = '0;
        if (digit_on) an_vec[idx] = 1'b1;
        an_out     = (AN_ACTIVE_LOW != 0) ? ~an_vec : an_vec;
        dp_out     = digit_on && sel_dp;
        blank_out  = !digit_on;
        digit_idx  = idx;
        frame_tick = (idx == IDX_LAST) && slot_end;
    end

endmodule
